core_bus_arbiter_n: RTL and testbench

//  N-channel arbiter sharing one core memory bus among fetch, load/store and other masters.

---
 rtl/core_bus_arbiter_n.sv | 178 +++++++++++++++++
 tb/tb_core_bus_arbiter_n.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter_n.sv
// N-channel arbiter that shares one core memory bus, with one transaction in flight at a time.
// Define ARBITER_ROUND_ROBIN_EN for round-robin grants; the default build uses fixed priority (channel 0 highest).
module core_bus_arbiter_n #(
  parameter int N  = 2,
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req_start,
  input  logic [N-1:0]        req_write,
  input  logic [N*AW-1:0]     req_addr,
  input  logic [N*DW-1:0]     req_data_wr,
  input  logic [N*DW/8-1:0]   req_data_be,
  output logic [N-1:0]        req_ready,
  output logic [DW-1:0]       req_data_rd,
  output logic [N-1:0]        req_overrun,
  output logic [AW-1:0]       bus_addr,
  output logic                bus_start,
  output logic                bus_write,
  output logic [DW-1:0]       bus_data_wr,
  output logic [DW/8-1:0]     bus_data_be,
  input  logic                bus_ready,
  input  logic [DW-1:0]       bus_data_rd
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   pick;
  logic            pick_valid;
  logic            done;
  logic [N-1:0]    pending;
  logic [N-1:0]    ch_write;
  logic [AW-1:0]   ch_addr  [N];
  logic [DW-1:0]   ch_wdata [N];
  logic [BW-1:0]   ch_be    [N];

  logic [N-1:0]    ready_q;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   bus_addr_q;
  logic            bus_write_q;
  logic [DW-1:0]   bus_wdata_q;
  logic [BW-1:0]   bus_be_q;

  assign done = (state_q == WAIT) && bus_ready;

  // A channel's request slot is frozen while pending, so the granted slot can feed the bus directly.
  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    logic            pend_q;
    logic            ovr_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [BW-1:0]   be_q;
    logic            clear_c;

    assign clear_c = done && (grant_q == IW'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q  <= 1'b0;
        ovr_q   <= 1'b0;
        wr_q    <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
        be_q    <= '0;
      end else if (req_start[gi] && !pend_q) begin
        pend_q  <= 1'b1;
        wr_q    <= req_write[gi];
        addr_q  <= req_addr[gi*AW +: AW];
        wdata_q <= req_data_wr[gi*DW +: DW];
        be_q    <= req_data_be[gi*BW +: BW];
      end else begin
        if (req_start[gi]) ovr_q <= 1'b1;
        if (clear_c) pend_q <= 1'b0;
      end
    end

    assign pending[gi]     = pend_q;
    assign req_overrun[gi] = ovr_q;
    assign ch_write[gi]    = wr_q;
    assign ch_addr[gi]     = addr_q;
    assign ch_wdata[gi]    = wdata_q;
    assign ch_be[gi]       = be_q;
  end

`ifdef ARBITER_ROUND_ROBIN_EN
  logic [IW-1:0] rr_q;
  int            rr_idx;

  // Scan downward so the last hit is the first pending channel at or after rr_q.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    rr_idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_idx = int'(rr_q) + k;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      if (pending[IW'(rr_idx)]) begin
        pick       = IW'(rr_idx);
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (state_q == IDLE && pick_valid) begin
      rr_q <= (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
    end
  end
`else
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pending[k]) begin
        pick       = IW'(k);
        pick_valid = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          grant_d = pick;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
      bus_addr_q  <= '0;
      bus_write_q <= 1'b0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= done ? ({{(N-1){1'b0}}, 1'b1} << grant_q) : '0;
      if (done) rdata_q <= bus_data_rd;
      if (state_q == IDLE && pick_valid) begin
        bus_addr_q  <= ch_addr[pick];
        bus_write_q <= ch_write[pick];
        bus_wdata_q <= ch_wdata[pick];
        bus_be_q    <= ch_be[pick];
      end
    end
  end

  assign bus_start   = (state_q == ISSUE);
  assign bus_addr    = bus_addr_q;
  assign bus_write   = bus_write_q;
  assign bus_data_wr = bus_wdata_q;
  assign bus_data_be = bus_be_q;
  assign req_ready   = ready_q;
  assign req_data_rd = rdata_q;

endmodule

// File: tb/tb_core_bus_arbiter_n.sv
// Bench for core_bus_arbiter_n: directed scenarios plus randomized traffic against a transaction-level model.
module tb_core_bus_arbiter_n;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_start, req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data_wr;
  logic [N*BW-1:0]   req_data_be;
  logic [N-1:0]      req_ready, req_overrun;
  logic [DW-1:0]     req_data_rd, bus_data_wr, bus_data_rd;
  logic [AW-1:0]     bus_addr;
  logic              bus_start, bus_write, bus_ready;
  logic [BW-1:0]     bus_data_be;

  int checks = 0;
  int errors = 0;
  int slv_cnt = 0;
  int slv_k = 1;

  always #5 clk = ~clk;

  core_bus_arbiter_n #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_start(req_start), .req_write(req_write), .req_addr(req_addr),
    .req_data_wr(req_data_wr), .req_data_be(req_data_be),
    .req_ready(req_ready), .req_data_rd(req_data_rd), .req_overrun(req_overrun),
    .bus_addr(bus_addr), .bus_start(bus_start), .bus_write(bus_write),
    .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
    .bus_ready(bus_ready), .bus_data_rd(bus_data_rd)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_start = '0; req_write = '0; req_addr = '0;
    req_data_wr = '0; req_data_be = '0;
    bus_ready = 1'b0; bus_data_rd = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    slv_cnt = 0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] be);
    req_start[c] = 1'b1;
    req_write[c] = w;
    req_addr[c*AW +: AW] = a;
    req_data_wr[c*DW +: DW] = d;
    req_data_be[c*BW +: BW] = be;
  endtask

  // Slave answers slv_k cycles after each bus_start; call once per cycle after sampling.
  task automatic slave_step();
    bus_ready = 1'b0;
    if (slv_cnt > 0) begin
      slv_cnt--;
      if (slv_cnt == 0) begin
        bus_ready = 1'b1;
        bus_data_rd = $urandom;
      end
    end
    if (bus_start === 1'b1) slv_cnt = slv_k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
    checks++; if (req_data_rd !== '0) begin errors++; $display("FAIL reset_req_data_rd got %h exp 0", req_data_rd); end
    checks++; if (req_overrun !== '0) begin errors++; $display("FAIL reset_overrun got %h exp 0", req_overrun); end
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL reset_bus_start got %b exp 0", bus_start); end
    checks++; if ({bus_addr, bus_write, bus_data_wr, bus_data_be} !== '0)
      begin errors++; $display("FAIL reset_bus_fields got %h/%b/%h/%h exp 0", bus_addr, bus_write, bus_data_wr, bus_data_be); end
    rst = 1'b0;
    tick();
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL reset_idle_start got %b exp 0", bus_start); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(1, 1'b0, 30'h100, '0, '0);
    tick();
    req_start = '0;
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL read_early_start got %b exp 0", bus_start); end
    tick();
    checks++; if (bus_start !== 1'b1) begin errors++; $display("FAIL read_start_T2 got %b exp 1", bus_start); end
    checks++; if (bus_addr !== 30'h100) begin errors++; $display("FAIL read_addr got %h exp 100", bus_addr); end
    checks++; if (bus_write !== 1'b0) begin errors++; $display("FAIL read_write got %b exp 0", bus_write); end
    tick();
    checks++; if (bus_start !== 1'b0) begin errors++; $display("FAIL read_start_width got %b exp 0", bus_start); end
    tick(); tick();
    bus_ready = 1'b1; bus_data_rd = 32'hDEADBEEF;
    tick();
    bus_ready = 1'b0; bus_data_rd = '0;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL read_ready_T6 got %b exp 0010", req_ready); end
    checks++; if (req_data_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h exp deadbeef", req_data_rd); end
    tick();
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL read_ready_pulse got %b exp 0000", req_ready); end
    $display("test_single_read ch1 addr 100 data %h", 32'hDEADBEEF);
  endtask

  task automatic test_priority();
    int n;
    logic [AW-1:0] addrs [2];
    logic wrs [2];
    do_reset();
    set_req(0, 1'b1, 30'h10, 32'h12345678, 4'hF);
    set_req(1, 1'b0, 30'h20, '0, '0);
    tick();
    req_start = '0;
    slv_k = 1; n = 0;
    addrs[0] = '0; addrs[1] = '0; wrs[0] = 1'b0; wrs[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus_start === 1'b1) begin
        if (n < 2) begin addrs[n] = bus_addr; wrs[n] = bus_write; end
        n++;
      end
      slave_step();
      tick();
    end
    checks++; if (n != 2) begin errors++; $display("FAIL prio_start_count got %0d exp 2", n); end
    checks++; if (addrs[0] !== 30'h10 || wrs[0] !== 1'b1) begin errors++; $display("FAIL prio_first got %h/%b exp 10/1", addrs[0], wrs[0]); end
    checks++; if (addrs[1] !== 30'h20 || wrs[1] !== 1'b0) begin errors++; $display("FAIL prio_second got %h/%b exp 20/0", addrs[1], wrs[1]); end
    $display("test_priority starts %0d", n);
  endtask

  task automatic test_overrun();
    int starts, readies;
    bit resent;
    logic [AW-1:0] seen_addr;
    do_reset();
    set_req(0, 1'b0, 30'h55, '0, '0);
    tick();
    set_req(0, 1'b1, 30'h99, 32'hFFFFFFFF, 4'hF);
    tick();
    req_start = '0;
    checks++; if (req_overrun !== 4'b0001) begin errors++; $display("FAIL ovr_set got %b exp 0001", req_overrun); end
    slv_k = 2; starts = 0; readies = 0; seen_addr = '0;
    for (int i = 0; i < 14; i++) begin
      if (bus_start === 1'b1) begin starts++; seen_addr = bus_addr; end
      if (req_ready[0] === 1'b1) readies++;
      slave_step();
      tick();
    end
    checks++; if (starts != 1 || readies != 1) begin errors++; $display("FAIL ovr_once got starts %0d readies %0d exp 1 1", starts, readies); end
    checks++; if (seen_addr !== 30'h55) begin errors++; $display("FAIL ovr_orig_addr got %h exp 55", seen_addr); end
    checks++; if (req_overrun !== 4'b0001) begin errors++; $display("FAIL ovr_sticky got %b exp 0001", req_overrun); end

    do_reset();
    set_req(0, 1'b0, 30'h66, '0, '0);
    tick();
    slv_k = 1; starts = 0; readies = 0; resent = 0;
    for (int i = 0; i < 16; i++) begin
      req_start = '0;
      if (bus_start === 1'b1) starts++;
      if (req_ready[0] === 1'b1) begin
        readies++;
        if (!resent) begin set_req(0, 1'b1, 30'h67, 32'h1, 4'h1); resent = 1; end
      end
      slave_step();
      tick();
    end
    checks++; if (starts != 2 || readies != 2) begin errors++; $display("FAIL ovr_ready_cycle got starts %0d readies %0d exp 2 2", starts, readies); end
    checks++; if (req_overrun !== '0) begin errors++; $display("FAIL ovr_ready_cycle_flag got %b exp 0000", req_overrun); end
    $display("test_overrun done");
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    set_req(2, 1'b0, 30'h77, '0, '0);
    tick();
    req_start = '0;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if ({bus_addr, bus_start} !== '0) begin errors++; $display("FAIL rstmid_async got %h/%b exp 0", bus_addr, bus_start); end
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      bus_ready = (i == 2);
      bus_data_rd = (i == 2) ? 32'hCAFEF00D : '0;
      tick();
      if ({req_ready, req_overrun, req_data_rd, bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be} !== '0) bad++;
    end
    bus_ready = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d nonzero cycles exp 0", bad); end
    $display("test_reset_mid done");
  endtask

  task automatic test_write_stable();
    int bad;
    do_reset();
    set_req(1, 1'b1, 30'h3C, 32'hAABBCCDD, 4'b0110);
    tick();
    req_start = '0;
    tick();
    checks++; if (bus_start !== 1'b1 || bus_write !== 1'b1) begin errors++; $display("FAIL wr_start got %b/%b exp 1/1", bus_start, bus_write); end
    checks++; if (bus_data_be !== 4'b0110) begin errors++; $display("FAIL wr_be got %b exp 0110", bus_data_be); end
    checks++; if (bus_data_wr !== 32'hAABBCCDD) begin errors++; $display("FAIL wr_data got %h exp aabbccdd", bus_data_wr); end
    slv_k = 3; bad = 0;
    slave_step();
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({bus_addr, bus_write, bus_data_wr, bus_data_be} !== {30'h3C, 1'b1, 32'hAABBCCDD, 4'b0110}) bad++;
      slave_step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wr_stable got %0d unstable cycles exp 0", bad); end
    tick();
    slave_step();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wr_ready got %b exp 0010", req_ready); end
    tick();
    checks++; if (bus_data_be !== 4'b0110 || bus_addr !== 30'h3C) begin errors++; $display("FAIL wr_hold got %b/%h exp 0110/3c", bus_data_be, bus_addr); end
    $display("test_write_stable ch1 be 0110 data aabbccdd");
  endtask

`ifdef ARBITER_ROUND_ROBIN_EN
  task automatic test_rr();
    int n;
    int order [12];
    int served [N];
    do_reset();
    for (int c = 0; c < N; c++) begin
      set_req(c, 1'b0, AW'(32'h40 + c), '0, '0);
      served[c] = 0;
    end
    tick();
    n = 0;
    for (int i = 0; i < 12; i++) order[i] = -1;
    for (int i = 0; i < 300 && n < 12; i++) begin
      req_start = '0;
      if (bus_start === 1'b1) begin
        order[n] = int'(bus_addr) - 32'h40;
        if (order[n] >= 0 && order[n] < N) served[order[n]]++;
        $display("rr txn %0d ch %0d", n, order[n]);
        n++;
      end
      for (int c = 0; c < N; c++)
        if (req_ready[c] === 1'b1) set_req(c, 1'b0, AW'(32'h40 + c), '0, '0);
      slv_k = $urandom_range(1, 3);
      slave_step();
      tick();
    end
    checks++; if (n != 12) begin errors++; $display("FAIL rr_count got %0d exp 12", n); end
    for (int i = 0; i < 12; i++) begin
      checks++; if (order[i] != i % N) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, order[i], i % N); end
    end
    for (int c = 0; c < N; c++) begin
      checks++; if (served[c] != 3) begin errors++; $display("FAIL rr_served[%0d] got %0d exp 3", c, served[c]); end
    end
  endtask
`endif

  // Transaction-level model: accepted requests wait in m_pend; one is granted per free cycle by policy.
  task automatic test_random();
    logic          m_pend [N];
    int            m_ts   [N];
    logic          m_w    [N];
    logic [AW-1:0] m_a    [N];
    logic [DW-1:0] m_d    [N];
    logic [BW-1:0] m_b    [N];
    logic [N-1:0]  m_ovr;
    bit            busy, issued;
    int            cur, start_at, rdy_drive_at, ready_at, rr;
    logic [DW-1:0] rd_val;
    do_reset();
    for (int c = 0; c < N; c++) begin
      m_pend[c] = 1'b0; m_ts[c] = 0; m_w[c] = 1'b0; m_a[c] = '0; m_d[c] = '0; m_b[c] = '0;
    end
    m_ovr = '0; busy = 0; issued = 0; cur = 0; rr = 0; rd_val = '0;
    start_at = -1; rdy_drive_at = -1; ready_at = -1;
    for (int p = 0; p < 600; p++) begin
      logic [N-1:0] exp_rdy;
      int g;
      exp_rdy = '0;
      if (p == ready_at) begin
        exp_rdy[cur] = 1'b1;
        m_pend[cur] = 1'b0;
        busy = 0; issued = 0;
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", p, req_ready, exp_rdy); end
      if (p == ready_at) begin
        checks++; if (req_data_rd !== rd_val) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", p, req_data_rd, rd_val); end
      end
      checks++; if (bus_start !== (p == start_at)) begin errors++; $display("FAIL rnd_start cyc %0d got %b exp %b", p, bus_start, p == start_at); end
      if (p == start_at) begin
        issued = 1;
        rdy_drive_at = p + $urandom_range(1, 4);
        ready_at = rdy_drive_at + 1;
        $display("rnd txn ch %0d %s addr %h", cur, m_w[cur] ? "wr" : "rd", m_a[cur]);
      end
      if (issued) begin
        checks++;
        if ({bus_addr, bus_write, bus_data_wr, bus_data_be} !== {m_a[cur], m_w[cur], m_d[cur], m_b[cur]}) begin
          errors++;
          $display("FAIL rnd_bus cyc %0d got %h/%b/%h/%h exp %h/%b/%h/%h", p, bus_addr, bus_write, bus_data_wr, bus_data_be,
                   m_a[cur], m_w[cur], m_d[cur], m_b[cur]);
        end
      end
      if (!busy) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          int c;
`ifdef ARBITER_ROUND_ROBIN_EN
          c = (rr + k) % N;
`else
          c = k;
`endif
          if (g < 0 && m_pend[c] && m_ts[c] <= p - 1) g = c;
        end
        if (g >= 0) begin
          busy = 1; cur = g; start_at = p + 1; rr = (g + 1) % N;
        end
      end
      checks++; if (req_overrun !== m_ovr) begin errors++; $display("FAIL rnd_overrun cyc %0d got %b exp %b", p, req_overrun, m_ovr); end

      req_start = '0;
      bus_ready = (p == rdy_drive_at) ? 1'b1 : (!(issued && p > start_at) && $urandom_range(0, 7) == 0);
      bus_data_rd = $urandom;
      if (p == rdy_drive_at) rd_val = bus_data_rd;
      for (int c = 0; c < N; c++) begin
        req_write[c] = 1'($urandom_range(0, 1));
        req_addr[c*AW +: AW] = AW'($urandom);
        req_data_wr[c*DW +: DW] = $urandom;
        req_data_be[c*BW +: BW] = BW'($urandom);
        if (p < 560 && $urandom_range(0, 5) == 0) begin
          req_start[c] = 1'b1;
          if (m_pend[c]) m_ovr[c] = 1'b1;
          else begin
            m_pend[c] = 1'b1; m_ts[c] = p;
            m_w[c] = req_write[c]; m_a[c] = req_addr[c*AW +: AW];
            m_d[c] = req_data_wr[c*DW +: DW]; m_b[c] = req_data_be[c*BW +: BW];
          end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_priority();
    test_overrun();
    test_reset_mid();
    test_write_stable();
`ifdef ARBITER_ROUND_ROBIN_EN
    test_rr();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
